// File: rtl/code.sv
// code: 15-unit vending FSM taking 5/10-unit coins, with dispense and change/refund pulses.
module code (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] x,
  output logic       z,
  output logic [1:0] change
);
  typedef enum logic [1:0] {S0 = 2'd0, S5 = 2'd1, S10 = 2'd2} state_t;
  localparam logic [1:0] NONE = 2'b00, COIN5 = 2'b01, COIN10 = 2'b10, CANCEL = 2'b11;
  state_t state;
  always_ff @(posedge clk) begin
    z      <= 1'b0;
    change <= 2'b00;
    if (rst) begin
      state <= S0;
    end else begin
      case (state)
        S0: state <= (x == COIN5) ? S5 : (x == COIN10) ? S10 : S0;
        S5: begin
          state  <= (x == NONE) ? S5 : (x == COIN5) ? S10 : S0;
          z      <= (x == COIN10);
          change <= (x == CANCEL) ? 2'b01 : 2'b00;
        end
        S10: begin
          state  <= (x == NONE) ? S10 : S0;
          z      <= (x == COIN5) || (x == COIN10);
          change <= (x == COIN10) ? 2'b01 : (x == CANCEL) ? 2'b10 : 2'b00;
        end
        default: state <= S0;
      endcase
    end
  end
endmodule

// File: tb/tb_code.sv
// tb_code: table-driven directed vectors plus a scoreboarded random run with a coin-value invariant.
module tb_code;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] x = 2'b00;
  logic       z;
  logic [1:0] change;
  int compared = 0;
  int mismatched = 0;
  logic [2:0] sb[$];

  typedef struct {
    logic       r;
    logic [1:0] x;
    logic       ez;
    logic [1:0] ec;
  } vec_t;
  vec_t tbl[$];

  code dut (.clk(clk), .rst(rst), .x(x), .z(z), .change(change));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Reference: returns {next_state, z, change}; credit encoded as 0/1/2 for 0/5/10 units.
  function automatic logic [4:0] model(input logic [1:0] s, input logic [1:0] xv);
    logic [1:0] c;
    c = (s > 2'd2) ? 2'd0 : s;
    if (c == 2'd0) return (xv == 2'b01) ? 5'b01_0_00 : (xv == 2'b10) ? 5'b10_0_00 : 5'b00_0_00;
    if (c == 2'd1) return (xv == 2'b00) ? 5'b01_0_00 : (xv == 2'b01) ? 5'b10_0_00 :
                          (xv == 2'b10) ? 5'b00_1_00 : 5'b00_0_01;
    return (xv == 2'b00) ? 5'b10_0_00 : (xv == 2'b01) ? 5'b00_1_00 :
           (xv == 2'b10) ? 5'b00_1_01 : 5'b00_0_10;
  endfunction

  task automatic step(input string name, input logic r, input logic [1:0] xv,
                      input logic ez, input logic [1:0] ec);
    logic [2:0] e;
    @(negedge clk);
    rst = r;
    x = xv;
    sb.push_back({ez, ec});
    @(posedge clk);
    #1;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL %s: scoreboard empty, got z=%b change=%b", name, z, change);
    end else begin
      e = sb.pop_front();
      if ({z, change} !== e) begin
        mismatched++;
        $display("FAIL %s: got z=%b change=%b, expected z=%b change=%b", name, z, change, e[2], e[1:0]);
      end
    end
  endtask

  initial begin
    logic [1:0] ms;
    logic [4:0] m;
    logic       rr;
    logic [1:0] xr;
    int sum_in, sum_out, discarded, credit;
    // {rst, x, z, change}
    tbl.push_back('{1'b1, 2'b11, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1'b1, 2'b01});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1'b1, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 2'b10});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 2'b01});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 2'b00});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1'b1, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 2'b00});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1'b1, 2'b01});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 2'b00});
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].r, tbl[i].x, tbl[i].ez, tbl[i].ec);

    ms = 2'd0;
    sum_in = 0;
    sum_out = 0;
    discarded = 0;
    for (int i = 0; i < 1200; i++) begin
      rr = (i == 0) || ($urandom_range(0, 49) == 0);
      xr = 2'($urandom_range(0, 3));
      credit = 5 * int'(ms);
      if (rr) begin
        discarded += credit;
        m = 5'b00_0_00;
      end else begin
        sum_in += (xr == 2'b01) ? 5 : (xr == 2'b10) ? 10 : 0;
        m = model(ms, xr);
      end
      step($sformatf("rand%0d", i), rr, xr, m[2], m[1:0]);
      sum_out += (z ? 15 : 0) + 5 * int'(change);
      ms = m[4:3];
    end
    compared++;
    if (sum_in != sum_out + 5 * int'(ms) + discarded) begin
      mismatched++;
      $display("FAIL invariant: got out+credit+discarded=%0d, expected coins in=%0d",
               sum_out + 5 * int'(ms) + discarded, sum_in);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/code.md
CODE -- requirements
Module: code

Interface
REQ-001 The module SHALL have no parameters; the price and coin values are fixed by this specification.
REQ-002 clk  input  1  sole clock; all state and outputs SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 x  input  2  coin code sampled every rising edge: 00 = no coin, 01 = 5-unit coin, 10 = 10-unit coin, 11 = cancel/refund.
REQ-005 z  output  1  registered dispense pulse; 1 for exactly one cycle per sale.
REQ-006 change  output  2  registered change/refund code: 00 = none, 01 = 5 units, 10 = 10 units, 11 = never driven.

Function
REQ-007 The block SHALL implement a vending FSM with an item price of 15 units and states S0 (credit 0), S5 (credit 5) and S10 (credit 10).
REQ-008 Every rising edge with rst=0 SHALL count as one sample of x; x held constant for N cycles SHALL count as N coins or N commands.
REQ-009 Transitions and outputs, all registered and visible from the edge that samples x until the next edge:
- S0: 00 -> S0; 01 -> S5; 10 -> S10; 11 -> S0, change=00.
- S5: 00 -> S5; 01 -> S10; 10 -> S0, z=1, change=00; 11 -> S0, change=01.
- S10: 00 -> S10; 01 -> S0, z=1, change=00; 10 -> S0, z=1, change=01; 11 -> S0, change=10.
REQ-010 In every cycle not listed in REQ-009 with z=1 or a nonzero change, z SHALL be 0 and change SHALL be 00.
- Outputs are one-cycle pulses and SHALL NOT be held.
REQ-011 Latency: the coin completing a sale SHALL produce z=1 in the cycle immediately after the sampling edge, with no wait states.
REQ-012 After a sale or refund, the next sampled coin SHALL start a new transaction from S0 in the very next cycle, so back-to-back sales are allowed.
REQ-013 z=1 and a nonzero change SHALL occur together only for the 20-unit overpay case (z=1, change=01).
- Refund (x=11) SHALL give z=0.
REQ-014 Cancel in S0 SHALL be a no-op with no output pulse.
REQ-015 The state register SHALL be 2 bits; the unused encoding SHALL return to S0 on the next edge with z=0 and change=00.

Reset
REQ-016 When rst=1 at a rising edge, the state SHALL become S0, z SHALL become 0 and change SHALL become 00, regardless of x or the current state.
REQ-017 Reset in mid-transaction (S5 or S10) SHALL discard the credit without a refund pulse.
REQ-018 Before the first reset edge, the outputs are undefined; the bench SHALL assert rst for at least one edge before checking outputs.
REQ-019 x SHALL be ignored on any edge where rst=1.

Verification
REQ-020 rst=1 for one edge, then x=01 held for 3 edges -> z=0, 0, 1 after edges 1-3, change=00 throughout; x=01 held for a further 3 edges -> z pulses again after edge 6.
REQ-021 From S0: x=10, then x=10 -> after the 2nd edge z=1 and change=01; the cycle after that, with x=00, z=0, change=00 and the state is S0.
REQ-022 From S0: x=01, then x=10 -> z=1 and change=00 after the 2nd edge; separately, x=10, then x=01 -> z=1 and change=00.
REQ-023 From S0: x=10, then x=11 -> z=0 and change=10 after the 2nd edge; x=01, then x=11 -> change=01; x=11 in S0 -> no pulse.
REQ-024 From S0: x=10, then rst=1 for one edge, then x=01 -> z=0 and change=00 throughout, and the state is S5; a further x=10 -> z=1 and change=00.
REQ-025 A random x sequence of at least 1000 cycles SHALL match a reference model exactly.
- Invariant: total coin value in = 15 × (number of z pulses) + value of all change pulses + credit remaining, with credit discarded at reset excluded.
